// File: rtl/power_mult_seq.sv
// Sequential shift-add power multiplier P = V * I, one current bit per clock,
// with valid/ready handshakes and a direction compare against the last delivered P.
module power_mult_seq #(
  parameter int WV = 6,
  parameter int WI = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WV-1:0]    v,
  input  logic [WI-1:0]    i,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WV+WI-1:0] p,
  output logic [1:0]       dp_cmp,
  output logic             first
);
  localparam int WP = WV + WI;
  localparam int CW = $clog2(WI + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t          state, state_nxt;
  logic [WP-1:0]   acc, mcand, acc_sum, p_prev;
  logic [WI-1:0]   mplier;
  logic [CW-1:0]   cnt;
  logic            last;

  // Accumulator value after this cycle's partial product; on the last BUSY
  // edge it is the finished product, so p is loaded straight from it.
  assign acc_sum = mplier[0] ? acc + mcand : acc;
  assign last    = (cnt == CW'(WI - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = BUSY;
      end
      BUSY: if (last) state_nxt = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
      p      <= '0;
      dp_cmp <= 2'b00;
      first  <= 1'b1;
      p_prev <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          mcand  <= WP'(v);
          mplier <= i;
          acc    <= '0;
          cnt    <= '0;
        end
        BUSY: begin
          acc    <= acc_sum;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + CW'(1);
          if (last) begin
            p <= acc_sum;
            // compare against the last handed-off result only
            if (first)                 dp_cmp <= 2'b00;
            else if (acc_sum > p_prev) dp_cmp <= 2'b01;
            else if (acc_sum < p_prev) dp_cmp <= 2'b10;
            else                       dp_cmp <= 2'b00;
          end
        end
        DONE: if (out_ready) begin
          p_prev <= p;
          first  <= 1'b0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_power_mult_seq.sv
// Scoreboard bench: drivers push v*i expectations, monitors pop on each handshake.
module tb_power_mult_seq;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n = 1'b0;

  // 6x6 instance
  logic in_valid, in_ready, out_valid, out_ready, first;
  logic [5:0] v, i;
  logic [11:0] p;
  logic [1:0] dp_cmp;
  // 10x8 instance
  logic in_valid2, in_ready2, out_valid2, first2;
  logic out_ready2 = 1'b1;
  logic [9:0] v2;
  logic [7:0] i2;
  logic [17:0] p2;
  logic [1:0] dp_cmp2;

  logic rand_bp = 1'b0, or_force = 1'b1, rnd_bit = 1'b1;
  assign out_ready = rand_bp ? rnd_bit : or_force;
  always @(posedge clk) begin #1; rnd_bit = 1'($urandom_range(0, 1)); end

  power_mult_seq #(.WV(6), .WI(6)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .v(v), .i(i),
    .out_valid(out_valid), .out_ready(out_ready), .p(p), .dp_cmp(dp_cmp), .first(first));

  power_mult_seq #(.WV(10), .WI(8)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2), .v(v2), .i(i2),
    .out_valid(out_valid2), .out_ready(out_ready2), .p(p2), .dp_cmp(dp_cmp2), .first(first2));

  typedef struct { logic [63:0] p; logic [1:0] c; logic f; } exp_t;
  exp_t q[$], q2[$];
  logic [63:0] mprev, mprev2;
  bit mfirst, mfirst2;
  int errors = 0, checks = 0;
  int cyc = 0, acc_cyc = 0, acc_cyc2 = 0;
  bit ov_d = 0, ov2_d = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: product in plain arithmetic; direction relative to the previous
  // delivered result, which is the previous pushed one since results hand off in order.
  function automatic exp_t model(input logic [63:0] prod, input logic [63:0] prev, input bit fst);
    exp_t e;
    e.p = prod;
    e.f = fst;
    if (fst)              e.c = 2'b00;
    else if (prod > prev) e.c = 2'b01;
    else if (prod < prev) e.c = 2'b10;
    else                  e.c = 2'b00;
    return e;
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst_n && in_valid && in_ready)   acc_cyc  <= cyc + 1;
    if (rst_n && in_valid2 && in_ready2) acc_cyc2 <= cyc + 1;
  end

  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_result: got p=%0d expected no result", p);
      end else begin
        chk("p", p, q[0].p);
        chk("dp_cmp", dp_cmp, q[0].c);
        chk("first", first, q[0].f);
        chk("in_ready_in_done", in_ready, 0);
        if (!ov_d) chk("latency", cyc - acc_cyc, 6);
        if (out_ready) void'(q.pop_front());
      end
    end
    ov_d = rst_n && out_valid;
  end

  always @(negedge clk) begin
    if (rst_n && out_valid2) begin
      if (q2.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_result2: got p=%0d expected no result", p2);
      end else begin
        chk("p2", p2, q2[0].p);
        chk("dp_cmp2", dp_cmp2, q2[0].c);
        chk("first2", first2, q2[0].f);
        if (!ov2_d) chk("latency2", cyc - acc_cyc2, 8);
        if (out_ready2) void'(q2.pop_front());
      end
    end
    ov2_d = rst_n && out_valid2;
  end

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    q.delete(); q2.delete();
    mprev = 0; mprev2 = 0; mfirst = 1; mfirst2 = 1;
  endtask

  task automatic send(input logic [5:0] vv, input logic [5:0] ii);
    int n = 0;
    in_valid = 1'b1; v = vv; i = ii;
    while (!in_ready && n < 200) begin @(posedge clk); #1; n++; end
    if (n >= 200) begin
      checks++; errors++;
      $display("FAIL accept_timeout: got in_ready=0 expected 1");
      in_valid = 1'b0;
      return;
    end
    q.push_back(model(64'(vv) * 64'(ii), mprev, mfirst));
    mprev = 64'(vv) * 64'(ii); mfirst = 0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("in_ready_busy", in_ready, 0);
  endtask

  task automatic send2(input logic [9:0] vv, input logic [7:0] ii);
    int n = 0;
    in_valid2 = 1'b1; v2 = vv; i2 = ii;
    while (!in_ready2 && n < 200) begin @(posedge clk); #1; n++; end
    if (n >= 200) begin
      checks++; errors++;
      $display("FAIL accept_timeout2: got in_ready=0 expected 1");
      in_valid2 = 1'b0;
      return;
    end
    q2.push_back(model(64'(vv) * 64'(ii), mprev2, mfirst2));
    mprev2 = 64'(vv) * 64'(ii); mfirst2 = 0;
    @(posedge clk); #1;
    in_valid2 = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((q.size() > 0 || q2.size() > 0) && n < 1000) begin @(posedge clk); #1; n++; end
    if (n >= 1000) begin
      checks++; errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", q.size() + q2.size());
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [5:0] rv, ri;
    int n;
    in_valid = 0; v = 0; i = 0; in_valid2 = 0; v2 = 0; i2 = 0;
    repeat (3) @(posedge clk);
    #1;
    do_reset();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_p", p, 0);
    chk("rst_dp_cmp", dp_cmp, 0);
    chk("rst_first", first, 1);

    send(63, 63); drain();

    do_reset();
    send(10, 5); send(12, 5); send(12, 4); send(12, 4); drain();

    send(45, 0); send(0, 63); drain();

    // backpressure: result held while new operands wait upstream
    or_force = 1'b0;
    send(7, 3);
    in_valid = 1'b1; v = 9; i = 9;
    n = 0;
    while (!out_valid && n < 50) begin @(posedge clk); #1; n++; end
    chk("bp_result_arrives", out_valid, 1);
    repeat (5) begin
      @(posedge clk); #1;
      chk("bp_in_ready", in_ready, 0);
      chk("bp_out_valid", out_valid, 1);
      chk("bp_p", p, 21);
    end
    or_force = 1'b1;
    send(9, 9); drain();

    // reset while computing discards the operation and the compare history
    send(40, 40);
    @(posedge clk); #1;
    @(posedge clk); #1;
    do_reset();
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_out_valid", out_valid, 0);
    send(2, 3); drain();

    rand_bp = 1'b1;
    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 3) == 0) begin
        rv = 6'($urandom_range(1, 3)); ri = 6'($urandom_range(1, 3));
      end else begin
        rv = 6'($urandom_range(0, 63)); ri = 6'($urandom_range(0, 63));
      end
      send(rv, ri);
    end
    drain();
    rand_bp = 1'b0;

    send2(1023, 255); send2(1, 1); drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/power_mult_seq.md
Name: power_mult_seq

Overview:
- Parametrised, multi-cycle shift-add multiplier that computes instantaneous power P = V * I from unsigned voltage and current samples, one current bit per clock.
- Replaces the fixed 6x6 single-cycle combinational power multiplier in the MPPT datapath.
- Adds valid/ready handshakes on both sides.
- Adds a comparison of each result against the previously delivered power, giving the perturb-and-observe controller its direction signal.

Parameters:
- WV, 6, voltage operand width in bits (unsigned), >=2
- WI, 6, current operand width in bits (unsigned), >=2; equals compute latency in cycles

Ports:
- clk  in  1  sole clock, rising edge
- rst_n  in  1  synchronous reset, active-low
- in_valid  in  1  operands v, i valid
- in_ready  out  1  block can accept operands
- v  in  WV  voltage sample
- i  in  WI  current sample
- out_valid  out  1  p, dp_cmp, first valid
- out_ready  in  1  consumer accepts result
- p  out  WV+WI  product v*i, exact, no truncation
- dp_cmp  out  2  p vs previous delivered p: 2'b01 greater, 2'b10 less, 2'b00 equal
- first  out  1  no previous result exists; dp_cmp forced 2'b00

Behaviour:
- Interface: one clock; reset is synchronous and active-low (clk, rst_n).
- Reset, when rst_n=0 at a rising edge:
  - state=IDLE, in_ready=1, out_valid=0, p=0, dp_cmp=0, first=1.
  - Internal accumulator, multiplicand, multiplier and counter are cleared.
  - p_prev=0.
- State machine:
  - IDLE:
    - in_ready=1, out_valid=0.
    - in_valid=1 at an edge latches mcand=v (zero-extended to WV+WI), mplier=i, acc=0, cnt=0, and moves to BUSY.
  - BUSY:
    - in_ready=0.
    - Each edge: if mplier[0], acc += mcand. Then mcand <<= 1, mplier >>= 1, cnt++.
    - After the WI-th BUSY edge (cnt reaches WI), the final acc is registered into p, dp_cmp and first are computed, and the state moves to DONE.
  - DONE:
    - out_valid=1; p, dp_cmp and first are held stable.
    - On out_valid & out_ready at an edge: p_prev <= p, first <= 0, state -> IDLE.
- Latency: exactly WI clock edges from the accepting edge to out_valid rising. Throughput: one result per WI+2 cycles minimum (accept, WI compute, handoff).
- No bit-skipping or early termination. Latency is data-independent, including i=0.
- Arithmetic: unsigned only. acc is WV+WI bits and never overflows, because the maximum product (2^WV-1)(2^WI-1) fits.
- Comparison: uses p_prev from the last handed-off result, not the last computed one. Results dropped by reset are never compared.
- in_valid during BUSY/DONE is ignored. Upstream must hold operands until in_ready.
- out_ready while out_valid=0 has no effect.
- out_ready held low keeps DONE indefinitely, with outputs stable and no new accept.
- Reset mid-BUSY or mid-DONE: in-flight operation is discarded, p_prev is cleared, first=1.
- Same-edge handoff and accept is not possible: in_ready=0 in DONE, so the next accept occurs no earlier than the edge after handoff.

Test Plan:
- Reset, then v=63, i=63, in_valid=1 for one edge -> in_ready=0 next cycle; out_valid=1 exactly 6 edges after accept; p=3969, first=1, dp_cmp=00.
- Sequence (out_ready=1): 10*5, 12*5, 12*4, 12*4 -> p=50,60,48,48; first=1,0,0,0; dp_cmp=00,01,10,00.
- v=45, i=0 -> out_valid still after 6 edges; p=0. Then v=0, i=63 -> p=0, dp_cmp=00.
- Backpressure: after result p=21 (7*3), hold out_ready=0 for 5 cycles while in_valid=1 with new operands -> out_valid and p=21 stay stable; in_ready=0 throughout. Release out_ready -> IDLE, then accept new operands.
- Reset asserted 3 cycles into BUSY (computing 40*40) -> next cycle in_ready=1, out_valid=0. Next op 2*3 gives p=6, first=1.
- Parameter set WV=10, WI=8: v=1023, i=255 -> p=260865 after 8 edges. Follow with v=1, i=1 -> p=1, dp_cmp=10.
